piradspi_sub_engine: RTL
========================

// Module: piradspi_sub_engine
//
// PURPOSE
//   SPI subordinate (target-side) engine: the far end of the piradspi master link. Oversamples
//   sclk/csn/mosi in the clk domain, deserialises MOSI into DATA_WIDTH words on an AXI-stream
//   manager (rx_*) and serialises words from an AXI-stream subordinate (tx_*) onto MISO.
//   Used as a loopback/peer model for the master and as an SPI target for external hosts.
//
// PARAMETERS
//   DATA_WIDTH    32  word width of rx/tx streams; bits shifted MSB first
//   CPOL           0  idle level of sclk
//   CPHA           0  0: sample on leading edge, shift on trailing; 1: shift leading, sample trailing
//   SYNC_STAGES    2  synchroniser depth on sclk, csn, mosi (>=2)
//   UNDERRUN_FILL  0  DATA_WIDTH-bit word driven on MISO when tx stream is empty
//
// PORTS
//   clk           in   1           system clock; must be >= 8x sclk frequency
//   rst           in   1           synchronous reset, active high
//   sclk          in   1           SPI clock from master (async)
//   csn           in   1           chip select, active low (async)
//   mosi          in   1           master-out data (async)
//   miso          out  1           subordinate-out data
//   miso_oe       out  1           MISO output enable; 1 only while selected
//   rx_tdata      out  DATA_WIDTH  received word
//   rx_tvalid     out  1           rx word valid
//   rx_tready     in   1           rx consumer ready
//   rx_tlast      out  1           word is last of frame (csn deasserted)
//   tx_tdata      in   DATA_WIDTH  word to transmit
//   tx_tvalid     in   1           tx word available
//   tx_tready     out  1           one-cycle pulse: tx word consumed
//   frame_active  out  1           selected and in ACTIVE state
//   frame_done    out  1           one-cycle pulse at end of frame
//   overrun       out  1           one-cycle pulse: rx word dropped (rx register still full)
//   underrun      out  1           one-cycle pulse: UNDERRUN_FILL loaded instead of tx word
//
// BEHAVIOUR
// - Reset: all outputs 0, miso=0, bit count 0, state WAIT_DESELECT. Reset mid-frame aborts;
//   engine never joins a frame already in progress (waits for csn high).
// - Inputs pass SYNC_STAGES flops; edges detected on synced sclk^CPOL one cycle later.
//   Sample-edge to internal shift: SYNC_STAGES+1 clk cycles.
// - States: WAIT_DESELECT -(csn_s=1)-> IDLE -(csn_s falls)-> ACTIVE -(csn_s rises)-> FLUSH -> IDLE.
// - IDLE->ACTIVE: load tx shift reg from tx_tdata with tx_tready pulse if tx_tvalid, else
//   UNDERRUN_FILL with underrun pulse; bit count=0; miso_oe=1; miso=shift MSB same cycle
//   (CPHA=0 first bit ready before first edge).
// - Sample edge: rx shift <= {rx[W-2:0], mosi_s}; count++. On count==DATA_WIDTH: count=0;
//   if rx_tvalid=0 or rx_tready=1 this cycle, rx_tdata<=word, rx_tvalid=1, rx_tlast=0; else
//   drop word, overrun pulse (held word kept).
// - Shift edge: tx shift left, miso=new MSB. CPHA=1: first leading edge drives MSB, no shift.
//   After the shift edge that follows a completed word, next tx word loaded (tx/underrun rule).
// - rx handshake: rx_tvalid holds until rx_tready; tdata/tlast stable while valid&~ready.
// - FLUSH (1 cycle): if count!=0, partial word right-aligned (upper bits 0) presented with
//   rx_tlast=1 under same overrun rule; if count==0, the held un-accepted word (if any) gets
//   rx_tlast=1, else no emission. frame_done pulses; miso_oe=0, miso=0; count=0.
// - Edge coincident with csn rise in same synced cycle: edge processed first, then FLUSH.
// - tx word prefetched but unused at frame end is discarded (already consumed).
//
// TESTING
// 1. CPOL=0,CPHA=0, master sends 0xDEADBEEF, tx=0x12345678 -> rx 0xDEADBEEF tlast=1; MISO bits = 0x12345678 MSB first.
// 2. CPHA=1,CPOL=1, 64-bit frame, tx words A5A5A5A5,5A5A5A5A -> two rx words, 2nd tlast=1; two tx_tready pulses.
// 3. 12-bit frame 0xABC -> rx_tdata=0x00000ABC, tlast=1, frame_done one cycle.
// 4. rx_tready=0 over 3-word frame -> first word held, overrun pulses twice, held word tlast=1.
// 5. tx_tvalid=0, UNDERRUN_FILL=0xFFFFFFFF -> MISO all ones, underrun pulse at select.
// 6. rst mid-frame, csn stays low 10 sclk -> no rx output until csn high then new frame works.

Source files
------------

// File: rtl/piradspi_sub_engine.sv
// SPI subordinate engine: oversamples sclk/csn/mosi in the clk domain, deserialises MOSI
// onto the rx AXI-stream and serialises words from the tx AXI-stream onto MISO.
module piradspi_sub_engine #(
    parameter int                    DATA_WIDTH    = 32,
    parameter logic                  CPOL          = 1'b0,
    parameter logic                  CPHA          = 1'b0,
    parameter int                    SYNC_STAGES   = 2,
    parameter logic [DATA_WIDTH-1:0] UNDERRUN_FILL = {DATA_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  csn,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    output logic [DATA_WIDTH-1:0] rx_tdata,
    output logic                  rx_tvalid,
    input  logic                  rx_tready,
    output logic                  rx_tlast,
    input  logic [DATA_WIDTH-1:0] tx_tdata,
    input  logic                  tx_tvalid,
    output logic                  tx_tready,
    output logic                  frame_active,
    output logic                  frame_done,
    output logic                  overrun,
    output logic                  underrun
);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        WAIT_DESELECT = 2'd0,
        IDLE          = 2'd1,
        ACTIVE        = 2'd2,
        FLUSH         = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic [SYNC_STAGES-1:0]  sclk_sync_r;
    logic [SYNC_STAGES-1:0]  csn_sync_r;
    logic [SYNC_STAGES-1:0]  mosi_sync_r;
    logic                    sclk_prev_r;
    logic                    sclk_s;
    logic                    csn_s;
    logic                    mosi_s;
    logic                    lead_s;
    logic                    trail_s;
    logic                    sample_s;
    logic                    shift_s;
    logic                    rx_free_s;
    logic [DATA_WIDTH-1:0]   tx_next_s;
    logic [DATA_WIDTH-1:0]   rx_word_s;
    logic [DATA_WIDTH-1:0]   rx_shift_r;
    logic [DATA_WIDTH-1:0]   tx_shift_r;
    logic [CW-1:0]           count_r;
    logic                    load_pend_r;
    logic                    first_r;

    // Input synchronisers; csn resets to "selected" so a frame already in flight is never joined
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_r <= {SYNC_STAGES{CPOL}};
            csn_sync_r  <= {SYNC_STAGES{1'b0}};
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
            sclk_prev_r <= 1'b0;
        end else begin
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk};
            csn_sync_r  <= {csn_sync_r[SYNC_STAGES-2:0], csn};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
            sclk_prev_r <= sclk_s;
        end
    end

    // Edge decode on the polarity-normalised synced clock, plus datapath helpers
    always_comb begin
        sclk_s  = sclk_sync_r[SYNC_STAGES-1] ^ CPOL;
        csn_s   = csn_sync_r[SYNC_STAGES-1];
        mosi_s  = mosi_sync_r[SYNC_STAGES-1];
        lead_s  = sclk_s & ~sclk_prev_r;
        trail_s = ~sclk_s & sclk_prev_r;
        if (CPHA) begin
            sample_s = trail_s;
            shift_s  = lead_s;
        end else begin
            sample_s = lead_s;
            shift_s  = trail_s;
        end
        tx_next_s = tx_tvalid ? tx_tdata : UNDERRUN_FILL;
        rx_word_s = {rx_shift_r[DATA_WIDTH-2:0], mosi_s};
        rx_free_s = ~rx_tvalid | rx_tready;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= WAIT_DESELECT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            WAIT_DESELECT: state_next_s = csn_s ? IDLE : WAIT_DESELECT;
            IDLE:          state_next_s = csn_s ? IDLE : ACTIVE;
            ACTIVE:        state_next_s = csn_s ? FLUSH : ACTIVE;
            FLUSH:         state_next_s = IDLE;
            default:       state_next_s = WAIT_DESELECT;
        endcase
    end

    // Shift registers, bit counter and registered stream/status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_shift_r   <= {DATA_WIDTH{1'b0}};
            tx_shift_r   <= {DATA_WIDTH{1'b0}};
            count_r      <= {CW{1'b0}};
            load_pend_r  <= 1'b0;
            first_r      <= 1'b0;
            miso         <= 1'b0;
            miso_oe      <= 1'b0;
            rx_tdata     <= {DATA_WIDTH{1'b0}};
            rx_tvalid    <= 1'b0;
            rx_tlast     <= 1'b0;
            tx_tready    <= 1'b0;
            frame_active <= 1'b0;
            frame_done   <= 1'b0;
            overrun      <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            tx_tready  <= 1'b0;
            underrun   <= 1'b0;
            overrun    <= 1'b0;
            frame_done <= 1'b0;
            if (rx_tvalid && rx_tready) begin
                rx_tvalid <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (!csn_s) begin
                        tx_shift_r   <= tx_next_s;
                        miso         <= tx_next_s[DATA_WIDTH-1];
                        tx_tready    <= tx_tvalid;
                        underrun     <= ~tx_tvalid;
                        rx_shift_r   <= {DATA_WIDTH{1'b0}};
                        count_r      <= {CW{1'b0}};
                        load_pend_r  <= 1'b0;
                        first_r      <= 1'b1;
                        miso_oe      <= 1'b1;
                        frame_active <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (sample_s) begin
                        if (count_r == CW'(DATA_WIDTH - 1)) begin
                            count_r     <= {CW{1'b0}};
                            rx_shift_r  <= {DATA_WIDTH{1'b0}};
                            load_pend_r <= 1'b1;
                            if (rx_free_s) begin
                                rx_tdata  <= rx_word_s;
                                rx_tvalid <= 1'b1;
                                rx_tlast  <= 1'b0;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            rx_shift_r <= rx_word_s;
                            count_r    <= count_r + CW'(1);
                        end
                    end
                    if (shift_s) begin
                        first_r <= 1'b0;
                        if (load_pend_r) begin
                            tx_shift_r  <= tx_next_s;
                            miso        <= tx_next_s[DATA_WIDTH-1];
                            tx_tready   <= tx_tvalid;
                            underrun    <= ~tx_tvalid;
                            load_pend_r <= 1'b0;
                        end else if (CPHA && first_r) begin
                            // CPHA=1: the first leading edge presents the MSB without shifting
                            miso <= tx_shift_r[DATA_WIDTH-1];
                        end else begin
                            tx_shift_r <= {tx_shift_r[DATA_WIDTH-2:0], 1'b0};
                            miso       <= tx_shift_r[DATA_WIDTH-2];
                        end
                    end
                end
                FLUSH: begin
                    count_r      <= {CW{1'b0}};
                    load_pend_r  <= 1'b0;
                    miso         <= 1'b0;
                    miso_oe      <= 1'b0;
                    frame_active <= 1'b0;
                    frame_done   <= 1'b1;
                    if (count_r != {CW{1'b0}}) begin
                        if (rx_free_s) begin
                            rx_tdata  <= rx_shift_r;
                            rx_tvalid <= 1'b1;
                            rx_tlast  <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else if (rx_tvalid && !rx_tready) begin
                        rx_tlast <= 1'b1;
                    end
                end
                default: begin
                    miso_oe      <= 1'b0;
                    frame_active <= 1'b0;
                end
            endcase
        end
    end
endmodule
